// File: rtl/ibus_sram_responder.sv
// ibus_sram_responder: answers instruction fetches from a single-port
// synchronous SRAM, one request in flight, with a per-request response delay.
//
// Handshake: a request is accepted in the cycle where ireq.valid and
// iresp.addr_ok are both high; the initiator holds valid/addr until then.
// iresp.data_ok pulses for exactly one cycle with iresp.data when the
// response is ready; there is no back-pressure on the response side.

package ibus_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

module ibus_sram_responder
  import ibus_pkg::*;
#(
  parameter int MEM_AW  = 12,
  parameter int DELAY_W = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  ibus_req_t           ireq,
  output ibus_resp_t          iresp,
  input  logic [DELAY_W-1:0]  delay,
  output logic                mem_en,
  output logic [MEM_AW-1:0]   mem_addr,
  input  logic [31:0]         mem_rdata,
  output logic [1:0]          dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]         state;
  logic [MEM_AW-1:0]  addr_q;
  logic [DELAY_W-1:0] cnt;
  logic               oor;
  logic [31:0]        data_q;

  logic addr_ok;
  logic accept;
  logic in_range;

  // Byte-offset bits never select anything: a misaligned fetch gets its word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^ireq.addr[1:0];

  // Acceptance and range decode; addr_ok is gated by reset so it reads 0
  // while resetn is low even though state is already IDLE.
  always_comb begin
    addr_ok  = (state == S_IDLE) && resetn;
    accept   = ireq.valid && addr_ok;
    in_range = (ireq.addr[31:MEM_AW+2] == '0);
  end

  // SRAM port: read strobe only in the accepting cycle of an in-range fetch;
  // otherwise the address lines rest on the last latched word address.
  always_comb begin
    mem_en   = accept && in_range;
    mem_addr = mem_en ? ireq.addr[MEM_AW+1:2] : addr_q;
  end

  // Response side is a pure function of state and the captured data.
  always_comb begin
    iresp.addr_ok = addr_ok;
    iresp.data_ok = (state == S_RESP);
    iresp.data    = data_q;
    dbg_state     = state;
  end

  // Request FSM: IDLE accepts, READ captures SRAM data, WAIT burns the
  // latched delay, RESP presents data_ok for one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      addr_q <= '0;
      cnt    <= '0;
      oor    <= 1'b0;
      data_q <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q <= ireq.addr[MEM_AW+1:2];
            cnt    <= delay;
            oor    <= !in_range;
            state  <= S_READ;
          end
        end
        S_READ: begin
          data_q <= oor ? 32'h0 : mem_rdata;
          state  <= (cnt != '0) ? S_WAIT : S_RESP;
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - DELAY_W'(1);
          end
          // cnt is at least 1 on entry, so this yields exactly 'delay' cycles.
          if (cnt <= DELAY_W'(1)) begin
            state <= S_RESP;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ibus_sram_responder.sv
// Testbench for ibus_sram_responder: table of directed fetches, hand-written
// reset-mid-request sequence, then randomized fetches against a
// transaction-level model (data = word or zero, data_ok at handshake+2+delay).

module tb_ibus_sram_responder;
  import ibus_pkg::*;

  localparam int AW = 12;
  localparam int DW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ibus_req_t         ireq;
  ibus_resp_t        iresp;
  logic [DW-1:0]     delay;
  logic              mem_en;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_rdata;
  logic [1:0]        dbg_state;

  ibus_sram_responder #(.MEM_AW(AW), .DELAY_W(DW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ireq      (ireq),
    .iresp     (iresp),
    .delay     (delay),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------- SRAM model ----------------
  // Synchronous read; garbage on cycles without a read so any sampling
  // outside READ shows up as wrong data.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_addr];
    else        mem_rdata <= $urandom;
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One fetch: present the request in the next cycle (must be accepted at
  // once), then scramble inputs and expect data_ok exactly 'lat' cycles later.
  task automatic do_fetch(input logic [31:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] d_after, input int lat);
    logic exp_en;
    logic [31:0] exp_data;
    exp_en = (a[31:AW+2] == '0);
    exp_q.push_back(exp_en ? mem[a[AW+1:2]] : 32'h0);
    @(posedge clk); #1;
    ireq.valid = 1'b1; ireq.addr = a; delay = d;
    @(negedge clk);
    chk("hs_addr_ok", {31'b0, iresp.addr_ok}, 32'd1);
    chk("hs_data_ok", {31'b0, iresp.data_ok}, 32'd0);
    chk("hs_mem_en", {31'b0, mem_en}, {31'b0, exp_en});
    if (exp_en) chk("hs_mem_addr", {20'b0, mem_addr}, {20'b0, a[AW+1:2]});
    exp_data = exp_q.pop_front();
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      ireq.valid = 1'($urandom_range(0, 1)); ireq.addr = $urandom; delay = d_after;
      @(negedge clk);
      chk("busy_addr_ok", {31'b0, iresp.addr_ok}, 32'd0);
      chk("busy_mem_en", {31'b0, mem_en}, 32'd0);
      chk("data_ok_timing", {31'b0, iresp.data_ok}, {31'b0, (k == lat)});
      if (k == lat) chk("resp_data", iresp.data, exp_data);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      ireq.valid = 1'b0; ireq.addr = $urandom;
      @(negedge clk);
      chk("idle_addr_ok", {31'b0, iresp.addr_ok}, 32'd1);
      chk("idle_data_ok", {31'b0, iresp.data_ok}, 32'd0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr_ok"}, {31'b0, iresp.addr_ok}, 32'd0);
    chk({tag, "_data_ok"}, {31'b0, iresp.data_ok}, 32'd0);
    chk({tag, "_data"}, iresp.data, 32'h0);
    chk({tag, "_mem_en"}, {31'b0, mem_en}, 32'd0);
    chk({tag, "_mem_addr"}, {20'b0, mem_addr}, 32'd0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0]   addr;
    logic [DW-1:0] d;
    logic [DW-1:0] d_after;
    logic [31:0]   exp_data;
    int            exp_lat;
  } vec_t;

  vec_t vecs [0:8];

  initial begin
    ireq.valid = 1'b0; ireq.addr = 32'h0; delay = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[3] = 32'h2402_0001;

    //           addr          d      d_after exp_data        lat
    vecs[0] = '{32'h0000_000C, 4'd0,  4'd0,  32'h2402_0001, 2};   // basic
    vecs[1] = '{32'h0000_000C, 4'd5,  4'd5,  32'h2402_0001, 7};   // delay 5
    vecs[2] = '{32'h0000_000C, 4'd15, 4'd15, 32'h2402_0001, 17};  // delay max
    vecs[3] = '{32'h0001_0000, 4'd0,  4'd0,  32'h0000_0000, 2};   // out of range
    vecs[4] = '{32'h0000_000E, 4'd0,  4'd0,  32'h2402_0001, 2};   // misaligned
    vecs[5] = '{32'h0000_0000, 4'd0,  4'd0,  32'hC0DE_0000, 2};   // back-to-back
    vecs[6] = '{32'h0000_0004, 4'd0,  4'd0,  32'hC0DE_0001, 2};
    vecs[7] = '{32'h0000_0008, 4'd0,  4'd0,  32'hC0DE_0002, 2};
    vecs[8] = '{32'h0000_0008, 4'd2,  4'd9,  32'hC0DE_0002, 4};   // delay changed

    // Reset with valid high: addr_ok must stay low.
    ireq.valid = 1'b1; ireq.addr = 32'h0000_000C;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    resetn = 1'b1; ireq.valid = 1'b0;
    @(negedge clk);
    chk("post_reset_addr_ok", {31'b0, iresp.addr_ok}, 32'd1);

    // Directed vectors; entries 5..7 run with no gap (handshake every 3 cycles).
    for (int i = 0; i < 9; i++) begin
      // table data is cross-checked against the SRAM-image rule
      chk("vec_model", vecs[i].exp_data,
          (vecs[i].addr[31:AW+2] == '0) ? mem[vecs[i].addr[AW+1:2]] : 32'h0);
      do_fetch(vecs[i].addr, vecs[i].d, vecs[i].d_after, vecs[i].exp_lat);
      if (i < 5 || i > 6) idle(1);
    end

    // Reset mid-request: handshake at T with delay 4, reset low at T+3 for 2 cycles.
    @(posedge clk); #1;
    ireq.valid = 1'b1; ireq.addr = 32'h0000_0014; delay = 4'd4;
    @(negedge clk);
    chk("rst_hs_addr_ok", {31'b0, iresp.addr_ok}, 32'd1);
    @(posedge clk); #1; ireq.valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; resetn = 1'b0;
    @(negedge clk);
    chk_reset_outputs("mid_rst1");
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_outputs("mid_rst2");
    @(posedge clk); #1; resetn = 1'b1;
    @(negedge clk);
    chk("rel_addr_ok", {31'b0, iresp.addr_ok}, 32'd1);
    idle(8);
    do_fetch(32'h0000_0018, 4'd1, 4'd7, 3);
    idle(1);

    // Randomized fetches against the transaction model.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      logic [DW-1:0] d;
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0001_0000;
      else a = 32'($urandom_range(0, 255));
      d = DW'($urandom_range(0, 15));
      do_fetch(a, d, DW'($urandom), int'(d) + 2);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ibus_sram_responder.md
# ibus_sram_responder

Instruction-bus responder that answers the core's fetch requests on the `ibus_req_t`/`ibus_resp_t` handshake (addr_ok on acceptance, one-cycle data_ok with data on completion). It sits between the CPU's fetch path and a single-port synchronous instruction SRAM. It serves one outstanding request at a time and adds a per-request programmable response delay so the initiator's wait states can be exercised.

## Interface
- `MEM_AW`, default 12: SRAM word-address width (4·2^MEM_AW bytes).
- `DELAY_W`, default 4: width of the `delay` input.
- `clk` in 1: clock; all state updates on the rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `ireq` in ibus_req_t: `valid`, `addr[31:0]` from the fetch initiator.
- `iresp` out ibus_resp_t: `addr_ok`, `data_ok`, `data[31:0]` to the initiator.
- `delay` in DELAY_W: extra response wait cycles; sampled on the accepting handshake.
- `mem_en` out 1: SRAM read enable.
- `mem_addr` out MEM_AW: SRAM word address.
- `mem_rdata` in 32: SRAM read data, valid the cycle after `mem_en`.

## Operation
- States: IDLE, READ, WAIT, RESP. Reset state IDLE.
- `iresp.addr_ok` = (state == IDLE) && resetn. It does not depend on `ireq.valid`.
- Handshake occurs when `ireq.valid && iresp.addr_ok`. In that cycle:
  - latch `addr`, latch `delay` into `cnt`;
  - if `addr[31:MEM_AW+2] == 0` (in range): drive `mem_en`=1 and `mem_addr`=`ireq.addr[MEM_AW+1:2]` combinationally. Otherwise `mem_en`=0 and set the `oor` flag;
  - next state is READ.
- `mem_en` is 0 in every other cycle. `mem_addr` holds the latched word address outside the handshake cycle.
- READ: `data_q` ← `oor` ? 32'h0 : `mem_rdata`. Next state is WAIT if `cnt` != 0, else RESP.
- WAIT: `cnt` ← `cnt` − 1. Leave for RESP when `cnt` == 1, so exactly `delay` cycles are spent in WAIT.
- RESP: `iresp.data_ok`=1 for exactly one cycle with `iresp.data`=`data_q`. Next state is IDLE.
- `iresp.data` = `data_q` in all states. It holds the last response until overwritten.
- `addr[1:0]` is ignored; a misaligned fetch returns the containing word.
- `ireq.valid` outside IDLE is ignored: no queuing, no error. The initiator is required to hold `valid` until `addr_ok`.
- The `cnt` decrement never wraps; `cnt` is only decremented while nonzero.

## Timing
- Handshake in cycle T gives `data_ok` in cycle T+2+delay. With delay=0, `data_ok` is at T+2.
- Next acceptance (`addr_ok`=1) is at T+3+delay. The peak rate is one fetch per 3 cycles.
- `data_ok` and `addr_ok` are never high in the same cycle.
- Reset values: state IDLE, `addr_ok`=0 while resetn=0 (1 from the first cycle after release), `data_ok`=0, `data`=32'h0, `mem_en`=0, `mem_addr`=0, `cnt`=0, `oor`=0.
- Reset asserted mid-request (READ/WAIT/RESP):
  - the request is dropped immediately and no `data_ok` is ever issued for it;
  - after release the block is in IDLE with `addr_ok`=1.
- A change of `delay` after the handshake has no effect on the in-flight request.
- `mem_rdata` is consumed only in READ. Its value in other cycles is don't-care.

## Test plan
- Basic fetch: SRAM word 3 = 32'h2402_0001, delay=0, `valid` with addr 32'h0000_000C at T → `addr_ok`=1 at T, `mem_en`=1 and `mem_addr`=3 at T, `data_ok`=1 with `data`=32'h2402_0001 only at T+2, `addr_ok`=1 again at T+3.
- Delay sweep: same fetch with delay=5 → `data_ok` only at T+7. With delay=15 → only at T+17. `addr_ok`=0 from T+1 through the `data_ok` cycle.
- Out of range: addr 32'h0001_0000 (MEM_AW=12) → `mem_en` stays 0, `data_ok` at T+2 with `data`=32'h0. Misaligned addr 32'h0000_000E → word 3 returned.
- Back-to-back: `valid` held continuously over addresses 0, 4, 8, delay=0 → handshakes at T, T+3, T+6, `data_ok` at T+2, T+5, T+8 with the matching words, no extra `data_ok`. Changing `valid`/`addr` between handshakes has no effect.
- Reset mid-request: handshake at T with delay=4, `resetn` low at T+3 for 2 cycles → `data_ok` never asserts for that request, all outputs at reset values, a new fetch after release completes normally.
- Delay changed after acceptance: delay=2 at handshake, delay=9 from T+1 → `data_ok` at T+4.
